// File: rtl/clock_display_pkg.sv
// Shared types and constants for the time-of-day clock and its seven-segment display.
// Segment patterns are active-low in CA..CG order, i.e. bit 6 = CA and bit 0 = CG.
package clock_display_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Field maxima as BCD tens/units pairs
    localparam logic [3:0] SEC_MAX_T  = 4'd5;
    localparam logic [3:0] SEC_MAX_U  = 4'd9;
    localparam logic [3:0] MIN_MAX_T  = 4'd5;
    localparam logic [3:0] MIN_MAX_U  = 4'd9;
    localparam logic [3:0] HR24_MAX_T = 4'd2;
    localparam logic [3:0] HR24_MAX_U = 4'd3;
    localparam logic [3:0] HR12_MAX_T = 4'd1;
    localparam logic [3:0] HR12_MAX_U = 4'd2;

endpackage

// File: rtl/clock_display_ctrl_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; any non-BCD value shows "E".
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_E;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/clock_display_ctrl.sv
// BCD time-of-day clock with button set mode, plus a 4-digit multiplexed display driver.
// Everything runs on one clock; the seconds and scan rates come from enable counters.
module clock_display_ctrl
    import clock_display_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter bit MODE_12H = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic       i_view_sel,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic       o_sec_tick
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int PRE_W    = $clog2(CLK_HZ);
    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF  = PRE_W'(CLK_HZ / 2);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [3:0] HR_MAX_T = MODE_12H ? HR12_MAX_T : HR24_MAX_T;
    localparam logic [3:0] HR_MAX_U = MODE_12H ? HR12_MAX_U : HR24_MAX_U;
    localparam logic [3:0] HR_MIN_U = MODE_12H ? 4'd1 : 4'd0;
    localparam logic [3:0] HR_RST_T = MODE_12H ? 4'd1 : 4'd0;
    localparam logic [3:0] HR_RST_U = MODE_12H ? 4'd2 : 4'd0;

    // Increment a two-digit BCD field, wrapping from its maximum to its minimum.
    function automatic logic [7:0] bcd_inc(
        input logic [3:0] tens,
        input logic [3:0] units,
        input logic [3:0] max_t,
        input logic [3:0] max_u,
        input logic [3:0] min_u
    );
        if (tens == max_t && units == max_u)
            bcd_inc = {4'd0, min_u};
        else if (units == 4'd9)
            bcd_inc = {tens + 4'd1, 4'd0};
        else
            bcd_inc = {tens, units + 4'd1};
    endfunction

    state_t              r_state;
    logic [PRE_W-1:0]    r_pre;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]          r_idx;
    logic [3:0]          r_hr_t, r_hr_u, r_mn_t, r_mn_u, r_sc_t, r_sc_u;
    logic                r_pm;
    logic                r_sec_tick;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic       w_wrap, w_sec_max, w_min_max, w_hr_eleven;
    logic [7:0] w_sec_inc, w_min_inc, w_hr_inc;
    logic       w_half, w_left, w_show_mmss, w_blank, w_dp_n;
    logic [3:0] w_digit;
    logic [6:0] w_seg_dec;

    assign w_wrap      = (r_pre == PRE_LAST);
    assign w_sec_max   = ({r_sc_t, r_sc_u} == {SEC_MAX_T, SEC_MAX_U});
    assign w_min_max   = ({r_mn_t, r_mn_u} == {MIN_MAX_T, MIN_MAX_U});
    assign w_hr_eleven = ({r_hr_t, r_hr_u} == 8'h11);
    assign w_sec_inc   = bcd_inc(r_sc_t, r_sc_u, SEC_MAX_T, SEC_MAX_U, 4'd0);
    assign w_min_inc   = bcd_inc(r_mn_t, r_mn_u, MIN_MAX_T, MIN_MAX_U, 4'd0);
    assign w_hr_inc    = bcd_inc(r_hr_t, r_hr_u, HR_MAX_T, HR_MAX_U, HR_MIN_U);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_pre      <= '0;
            r_sec_tick <= 1'b0;
            r_hr_t     <= HR_RST_T;
            r_hr_u     <= HR_RST_U;
            r_mn_t     <= 4'd0;
            r_mn_u     <= 4'd0;
            r_sc_t     <= 4'd0;
            r_sc_u     <= 4'd0;
            r_pm       <= 1'b0;
        end else begin
            r_pre      <= w_wrap ? '0 : r_pre + 1'b1;
            r_sec_tick <= 1'b0;
            case (r_state)
                RUN: begin
                    // sec_tick marks advancing time, so it only pulses while running
                    if (w_wrap) begin
                        r_sec_tick       <= 1'b1;
                        {r_sc_t, r_sc_u} <= w_sec_inc;
                        if (w_sec_max) begin
                            {r_mn_t, r_mn_u} <= w_min_inc;
                            if (w_min_max) begin
                                {r_hr_t, r_hr_u} <= w_hr_inc;
                                if (MODE_12H && w_hr_eleven)
                                    r_pm <= ~r_pm;
                            end
                        end
                    end
                    if (i_btn_mode)
                        r_state <= SET_HR;
                end
                SET_HR: begin
                    if (i_btn_mode)
                        r_state <= SET_MIN;
                    else if (i_btn_inc)
                        {r_hr_t, r_hr_u} <= w_hr_inc;
                end
                SET_MIN: begin
                    if (i_btn_mode) begin
                        r_state <= RUN;
                        r_sc_t  <= 4'd0;
                        r_sc_u  <= 4'd0;
                        r_pre   <= '0;
                    end else if (i_btn_inc) begin
                        {r_mn_t, r_mn_u} <= w_min_inc;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_show_mmss = (r_state == RUN) && i_view_sel;
    assign w_half      = (r_pre < PRE_HALF);
    assign w_left      = r_idx[1];
    assign w_blank     = w_half && ((r_state == SET_HR && w_left) ||
                                    (r_state == SET_MIN && !w_left));
    assign w_dp_n      = ~((r_idx == 2'd2 && r_state == RUN && w_half) ||
                           (r_idx == 2'd0 && MODE_12H && r_pm));

    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            2'd3:    w_digit = w_show_mmss ? r_mn_t : r_hr_t;
            2'd2:    w_digit = w_show_mmss ? r_mn_u : r_hr_u;
            2'd1:    w_digit = w_show_mmss ? r_sc_t : r_mn_t;
            default: w_digit = w_show_mmss ? r_sc_u : r_mn_u;
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd3;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b1;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx - 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? SEG_BLANK : w_seg_dec;
            r_dp  <= w_dp_n;
        end
    end

    assign o_an       = r_an;
    assign o_seg      = r_seg;
    assign o_dp       = r_dp;
    assign o_sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Bench for clock_display_ctrl: a 24 h and a 12 h instance share stimulus and are checked
// every cycle against an integer hours/minutes/seconds model of the clock and display.
module tb_clock_display_ctrl;
    import clock_display_pkg::*;

    localparam int CLK_HZ   = 8;
    localparam int SCAN_HZ  = 4;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;
    logic view_sel = 1'b0;
    logic [3:0] an24, an12;
    logic [6:0] seg24, seg12;
    logic       dp24, dp12, tick24, tick12;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_display_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MODE_12H(1'b0)) dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
        .i_view_sel(view_sel), .o_an(an24), .o_seg(seg24), .o_dp(dp24), .o_sec_tick(tick24)
    );

    clock_display_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .MODE_12H(1'b1)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
        .i_view_sel(view_sel), .o_an(an12), .o_seg(seg12), .o_dp(dp12), .o_sec_tick(tick12)
    );

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Reference model: index 0 = 24 h instance, index 1 = 12 h instance
    int m_hr [2];
    int m_mn [2];
    int m_sc [2];
    int m_pm [2];
    int m_pre, m_edges, m_state;  // m_state: 0 run, 1 set hours, 2 set minutes
    bit m_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hr[0] = 0;  m_hr[1] = 12;
        for (int m = 0; m < 2; m++) begin
            m_mn[m] = 0; m_sc[m] = 0; m_pm[m] = 0;
        end
        m_pre = 0; m_edges = 0; m_state = 0; m_tick = 0;
    endtask

    function automatic int hour_step(input int m, input int h);
        return (m == 0) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    task automatic model_edge(input bit bm, input bit bi);
        bit wrap, clr;
        wrap = (m_pre == CLK_HZ - 1);
        clr = 0;
        m_tick = 0;
        case (m_state)
            0: begin
                if (wrap) begin
                    m_tick = 1;
                    for (int m = 0; m < 2; m++) begin
                        m_sc[m] = (m_sc[m] + 1) % 60;
                        if (m_sc[m] == 0) begin
                            m_mn[m] = (m_mn[m] + 1) % 60;
                            if (m_mn[m] == 0) begin
                                m_hr[m] = hour_step(m, m_hr[m]);
                                if (m == 1 && m_hr[m] == 12) m_pm[m] = 1 - m_pm[m];
                            end
                        end
                    end
                end
                if (bm) m_state = 1;
            end
            1: begin
                if (bm) m_state = 2;
                else if (bi) for (int m = 0; m < 2; m++) m_hr[m] = hour_step(m, m_hr[m]);
            end
            default: begin
                if (bm) begin
                    m_state = 0; clr = 1;
                    for (int m = 0; m < 2; m++) m_sc[m] = 0;
                end else if (bi) begin
                    for (int m = 0; m < 2; m++) m_mn[m] = (m_mn[m] + 1) % 60;
                end
            end
        endcase
        m_pre = (clr || wrap) ? 0 : m_pre + 1;
        m_edges++;
    endtask

    // Pins registered on the next edge, derived from the model state before that edge.
    task automatic exp_pins(input int m, input bit vs, output logic [3:0] an,
                            output logic [6:0] seg, output logic dp);
        int dig[4];
        int idx, left, right;
        bit mmss, half, blank;
        idx   = 3 - (m_edges / SCAN_DIV) % 4;
        mmss  = (m_state == 0) && vs;
        left  = mmss ? m_mn[m] : m_hr[m];
        right = mmss ? m_sc[m] : m_mn[m];
        dig[3] = left / 10;  dig[2] = left % 10;
        dig[1] = right / 10; dig[0] = right % 10;
        half  = (m_pre < CLK_HZ / 2);
        blank = half && ((m_state == 1 && idx >= 2) || (m_state == 2 && idx <= 1));
        seg   = blank ? 7'b1111111 : seg_tab[dig[idx]];
        dp    = !((idx == 2 && m_state == 0 && half) || (idx == 0 && m == 1 && m_pm[m] == 1));
        an    = 4'b1111;
        an[idx] = 1'b0;
    endtask

    function automatic logic [23:0] bcd_time(input int m);
        return {4'(m_hr[m] / 10), 4'(m_hr[m] % 10), 4'(m_mn[m] / 10),
                4'(m_mn[m] % 10), 4'(m_sc[m] / 10), 4'(m_sc[m] % 10)};
    endfunction

    task automatic step(input bit bm, input bit bi, input bit vs);
        logic [3:0] ea0, ea1;
        logic [6:0] es0, es1;
        logic       ed0, ed1;
        btn_mode = bm; btn_inc = bi; view_sel = vs;
        exp_pins(0, vs, ea0, es0, ed0);
        exp_pins(1, vs, ea1, es1, ed1);
        @(posedge clk); #1;
        model_edge(bm, bi);
        btn_mode = 1'b0; btn_inc = 1'b0;
        check("an24", an24, ea0);   check("an12", an12, ea1);
        check("seg24", seg24, es0); check("seg12", seg12, es1);
        check("dp24", dp24, ed0);   check("dp12", dp12, ed1);
        check("tick24", tick24, m_tick); check("tick12", tick12, m_tick);
        check("time24", {dut24.r_hr_t, dut24.r_hr_u, dut24.r_mn_t, dut24.r_mn_u,
                         dut24.r_sc_t, dut24.r_sc_u}, bcd_time(0));
        check("time12", {dut12.r_hr_t, dut12.r_hr_u, dut12.r_mn_t, dut12.r_mn_u,
                         dut12.r_sc_t, dut12.r_sc_u}, bcd_time(1));
        check("pm12", dut12.r_pm, m_pm[1]);
    endtask

    task automatic rstep(input int n);
        repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic press(input bit bm, input bit bi);
        step(bm, bi, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an24"}, an24, 4'b1111);     check({tag, "_an12"}, an12, 4'b1111);
        check({tag, "_seg24"}, seg24, 7'h7F);     check({tag, "_seg12"}, seg12, 7'h7F);
        check({tag, "_dp24"}, dp24, 1'b1);        check({tag, "_dp12"}, dp12, 1'b1);
        check({tag, "_tick24"}, tick24, 1'b0);    check({tag, "_tick12"}, tick12, 1'b0);
    endtask

    initial begin
        int ticks;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_pins("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // First second, then a full minute
        ticks = 0;
        repeat (8) begin
            rstep(1);
            if (tick24) ticks++;
        end
        check("ticks_in_8", ticks, 1);
        check("ss_after_8", {dut24.r_sc_t, dut24.r_sc_u}, 8'h01);
        rstep(472);
        check("mmss_after_480", {dut24.r_mn_t, dut24.r_mn_u, dut24.r_sc_t, dut24.r_sc_u}, 16'h0100);

        // Set 23:59 (24 h) / 11:59 (12 h), then run one minute across the hour boundary
        press(1'b1, 1'b0);
        while (m_hr[0] != 23) begin
            press(1'b0, 1'b1);
            rstep($urandom_range(0, 2));
        end
        press(1'b1, 1'b0);
        while (m_mn[0] != 59) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("set_2359", {dut24.r_hr_t, dut24.r_hr_u, dut24.r_mn_t, dut24.r_mn_u}, 16'h2359);
        check("set_1159", {dut12.r_hr_t, dut12.r_hr_u, dut12.r_mn_t, dut12.r_mn_u}, 16'h1159);
        rstep(480);
        check("rollover24", {dut24.r_hr_t, dut24.r_hr_u, dut24.r_mn_t, dut24.r_mn_u,
                             dut24.r_sc_t, dut24.r_sc_u}, 24'h000000);
        check("rollover12", {dut12.r_hr_t, dut12.r_hr_u, dut12.r_mn_t, dut12.r_mn_u,
                             dut12.r_sc_t, dut12.r_sc_u}, 24'h120000);
        check("pm_set", dut12.r_pm, 1'b1);
        repeat (8) begin
            rstep(1);
            if (an12 == 4'b1110) check("dp_pm_digit0", dp12, 1'b0);
        end

        // Five hour increments, then simultaneous mode+inc
        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        check("hr_after_5inc", {dut24.r_hr_t, dut24.r_hr_u}, 8'h05);
        check("hr12_after_5inc", {dut12.r_hr_t, dut12.r_hr_u}, 8'h05);
        press(1'b1, 1'b1);
        check("combo_state", dut24.r_state, SET_MIN);
        check("combo_hr", {dut24.r_hr_t, dut24.r_hr_u}, 8'h05);
        check("combo_mn", {dut24.r_mn_t, dut24.r_mn_u}, 8'h00);
        repeat (6) begin
            press(1'b0, 1'b1);
            rstep(3);
        end

        // Asynchronous reset in the middle of a cycle while in SET_MIN
        check("pre_reset_state", dut24.r_state, SET_MIN);
        #3 rst_n = 1'b0;
        #1 check_reset_pins("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_reset_state", dut24.r_state, RUN);
        check("post_reset_time24", {dut24.r_hr_t, dut24.r_hr_u, dut24.r_mn_t, dut24.r_mn_u,
                                    dut24.r_sc_t, dut24.r_sc_u}, 24'h000000);
        check("post_reset_time12", {dut12.r_hr_t, dut12.r_hr_u, dut12.r_mn_t, dut12.r_mn_u,
                                    dut12.r_sc_t, dut12.r_sc_u}, 24'h120000);

        // 01:00 on HH:MM: check the leftmost two digit patterns through the scan
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (16) begin
            step(1'b0, 1'b0, 1'b0);
            if (an24 == 4'b0111) check("seg_digit3_0", seg24, 7'b0000001);
            if (an24 == 4'b1011) check("seg_digit2_1", seg24, 7'b1001111);
        end

        // Random buttons and view selection
        repeat (1500)
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_display_ctrl.md
# clock_display_ctrl

Parametrised time-of-day clock and 4-digit seven-segment display controller for the Nexys-2 display. It counts hours, minutes and seconds in BCD, and supports 24 h or 12 h mode. A button-driven set-mode state machine adjusts the time, and the block multiplexes HH:MM or MM:SS onto the active-low anode/cathode pins. It replaces the derived-clock divider chain with single-clock enable ticks and is the top-level timekeeping core.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; must be even and divisible by SCAN_HZ
- SCAN_HZ, 1000, digit-advance rate of the multiplexer (Hz)
- MODE_12H, 0, 0 = 24 h (00–23), 1 = 12 h (12,01–11 plus PM flag)
- clock  in  1  system clock, the only clock; all flops on rising edge
- reset  in  1  asynchronous, active-low reset
- btn_mode  in  1  single-cycle pulse, pre-debounced; advances set-mode FSM
- btn_inc  in  1  single-cycle pulse, pre-debounced; increments field being set
- view_sel  in  1  0 = show HH:MM, 1 = show MM:SS (RUN only)
- an  out  4  active-low anode select, an[3] leftmost
- seg  out  7  active-low cathodes, seg[6]=CA … seg[0]=CG
- dp  out  1  active-low decimal point
- sec_tick  out  1  one-cycle pulse per elapsed second

## Operation
- Prescaler counts 0..CLK_HZ-1 continuously (all states) and is $clog2(CLK_HZ) bits wide. A "wrap" occurs when it equals CLK_HZ-1.
- Time is held in BCD digits: SS/MM each tens 0–5 and units 0–9; HH per mode.
- RUN: each wrap increments SS. Carries propagate as 59→00 to the next field. In 24 h mode 23:59:59→00:00:00. In 12 h mode 12→01, and 11:59:59→12:00:00 toggles PM.
- FSM states and transitions:
  - RUN → SET_HR → SET_MIN → RUN, each on btn_mode.
  - Leaving SET_MIN clears SS to 00 and the prescaler to 0.
- SET_HR / SET_MIN: time does not advance.
  - btn_inc increments the selected field with wrap and no carry: hours 23→00 (12 h: 12→01, PM unchanged); minutes 59→00.
- btn_mode and btn_inc in the same cycle: the mode transition wins and the increment is discarded.
- Display source:
  - SET states always show HH:MM.
  - RUN shows HH:MM when view_sel=0 and MM:SS when view_sel=1.
  - In SET states the selected field's two digits are blanked (seg=7'b1111111) while prescaler < CLK_HZ/2.
- Digit scan: the index advances 3→2→1→0→3 every CLK_HZ/SCAN_HZ cycles. an is one-hot low for the index (3 → 4'b0111).
- Decode patterns:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - non-BCD = 0110000 ("E")
- dp:
  - Low on digit 2 in RUN while prescaler < CLK_HZ/2 (blinking colon).
  - Low on digit 0 when MODE_12H and PM.
  - High otherwise.

## Timing
- Reset asserted:
  - Outputs go immediately, with no clock edge: an=4'b1111, seg=7'b1111111, dp=1, sec_tick=0.
  - Internal state: RUN, prescaler 0, scan index 3.
  - Time: 00:00:00, or 12:00:00 AM in 12 h mode.
- Reset mid-operation, in any state, has the same effect.
- Time fields update on the edge where the prescaler wraps. sec_tick is registered and is high for exactly the following cycle, coincident with the new values.
- First sec_tick: in cycle CLK_HZ after reset release, counting the first cycle as cycle 0.
- an, seg and dp are registered: one cycle of latency after a scan-index or time change.
- Button effects are visible in internal state on the edge that samples the pulse, and on the pins one cycle later.

## Structure
- Package clock_display_pkg holds:
  - the state enum (RUN, SET_HR, SET_MIN)
  - the segment pattern constants, including blank and "E"
  - the field maxima.
- Sub-module seg7_decode: a combinational BCD-to-segment decoder, instantiated once after the digit mux.
- BCD field increment logic is kept as a local function; no further sub-modules.

## Test plan
Bench parameters: CLK_HZ=8, SCAN_HZ=4, so the digit advances every 2 cycles.
- Release reset, run 8 cycles → sec_tick pulses once and SS=01. After 480 cycles → MM=01, SS=00.
- Set HH=23 and MM=59 via buttons, return to RUN, run 60 seconds → time 00:00:00. HH never shows 24.
- MODE_12H=1, set 11:59, run 60 seconds → 12:00:00 with PM=1. dp is low whenever an=4'b1110.
- In RUN, send btn_mode then 5× btn_inc → HH=05. Then send btn_mode and btn_inc in the same cycle → state SET_MIN, HH=05, MM unchanged.
- Scan check → an cycles 0111, 1011, 1101, 1110, each held 2 cycles. At HH:MM=01:00, seg equals 0000001 on digit 3 and 1001111 on digit 2.
- Assert reset asynchronously mid-SET_MIN → an=1111 and seg=1111111 before the next edge. After release: RUN, time 00:00:00.
